// File: rtl/memctrl_pkg.sv
// Shared types for memctrl: MEM command/size encodings, FSM states and read-source tags.
// Imported by the controller; no logic of its own beyond the size decode.
package memctrl_pkg;
    localparam int          BYTE_W    = 8;
    localparam logic [31:0] ZERO_WORD = 32'h0;
    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;

    typedef enum logic [1:0] { RW_IDLE = 2'b00, RW_READ = 2'b01, RW_WRITE = 2'b10 } mem_rw_e;
    typedef enum logic [1:0] { LEN_B = 2'b00, LEN_H = 2'b01, LEN_W = 2'b11 } mem_len_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WAIT_RD,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] { SRC_NONE, SRC_IF, SRC_MEM } src_e;

    // Source of a RAM read in flight; idx is the MEM byte lane, last marks the final MEM byte.
    typedef struct packed {
        src_e       src;
        logic [1:0] idx;
        logic       last;
    } tag_t;

    // Reserved size code 10 behaves as a half-word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_W:   return 3'd4;
            default: return 3'd2;
        endcase
    endfunction
endpackage

// File: rtl/memctrl.sv
// Byte RAM responder: IF byte reads (latency 2, one per cycle) arbitrated against 1/2/4-byte MEM loads/stores.
// No backpressure: MEM wins the IDLE slot and a losing or non-IDLE if_req is dropped without response.
module memctrl
    import memctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [7:0]        if_rdata,
    input  logic [1:0]        mem_rw,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);
    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    tag_t              tag0_q, tag0_d, tag1_q, tag1_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [7:0]        if_rdata_q, if_rdata_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic [2:0]        acc_len;

    assign acc_len = len_bytes(mem_len);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tag0_d      = '0;
        tag1_d      = tag0_q;
        ram_a_d     = ram_a_q;
        ram_wr_d    = DISABLE;
        ram_dout_d  = ram_dout_q;
        if_rvalid_d = DISABLE;
        if_rdata_d  = if_rdata_q;
        mem_done_d  = DISABLE;
        mem_rdata_d = mem_rdata_q;

        // Retire the read issued two edges ago; RAM data is valid now.
        if (tag1_q.src == SRC_IF) begin
            if_rvalid_d = ENABLE;
            if_rdata_d  = ram_din;
        end else if (tag1_q.src == SRC_MEM) begin
            if (tag1_q.idx == 2'd0) begin
                mem_rdata_d = {{(32-BYTE_W){1'b0}}, ram_din};
            end else begin
                mem_rdata_d[{tag1_q.idx, 3'b000} +: BYTE_W] = ram_din;
            end
            if (tag1_q.last) mem_done_d = ENABLE;
        end

        case (state_q)
            ST_IDLE: begin
                if (mem_rw == RW_READ) begin
                    addr_d      = mem_addr;
                    len_d       = acc_len;
                    ram_a_d     = mem_addr;
                    tag0_d.src  = SRC_MEM;
                    tag0_d.idx  = 2'd0;
                    tag0_d.last = (acc_len == 3'd1);
                    cnt_d       = 3'd1;
                    state_d     = (acc_len == 3'd1) ? ST_WAIT_RD : ST_MEM_RD;
                end else if (mem_rw == RW_WRITE) begin
                    addr_d     = mem_addr;
                    len_d      = acc_len;
                    wdata_d    = mem_wdata;
                    ram_a_d    = mem_addr;
                    ram_dout_d = mem_wdata[7:0];
                    ram_wr_d   = ENABLE;
                    cnt_d      = 3'd1;
                    state_d    = ST_MEM_WR;
                end else if (if_req) begin
                    ram_a_d    = if_addr;
                    tag0_d.src = SRC_IF;
                end
            end
            ST_MEM_RD: begin
                ram_a_d     = addr_q + ADDR_W'(cnt_q);
                tag0_d.src  = SRC_MEM;
                tag0_d.idx  = cnt_q[1:0];
                tag0_d.last = (cnt_q == len_q - 3'd1);
                cnt_d       = cnt_q + 3'd1;
                if (cnt_q == len_q - 3'd1) state_d = ST_WAIT_RD;
            end
            ST_MEM_WR: begin
                if (cnt_q == len_q) begin
                    mem_done_d = ENABLE;
                    state_d    = ST_DONE;
                end else begin
                    ram_a_d    = addr_q + ADDR_W'(cnt_q);
                    ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: BYTE_W];
                    ram_wr_d   = ENABLE;
                    cnt_d      = cnt_q + 3'd1;
                end
            end
            ST_WAIT_RD: begin
                if (tag1_q.src == SRC_MEM && tag1_q.last) state_d = ST_DONE;
            end
            // The MEM stage drops mem_rw during this cycle, so it must not re-trigger.
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= ZERO_WORD;
            tag0_q      <= '0;
            tag1_q      <= '0;
            ram_a_q     <= '0;
            ram_wr_q    <= DISABLE;
            ram_dout_q  <= 8'h0;
            if_rvalid_q <= DISABLE;
            if_rdata_q  <= 8'h0;
            mem_done_q  <= DISABLE;
            mem_rdata_q <= ZERO_WORD;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tag0_q      <= tag0_d;
            tag1_q      <= tag1_d;
            ram_a_q     <= ram_a_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            mem_done_q  <= mem_done_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;
    assign ram_a     = ram_a_q;
    assign ram_wr    = ram_wr_q;
    assign ram_dout  = ram_dout_q;
endmodule

// File: tb/tb_memctrl.sv
// Self-checking bench for memctrl: directed scenarios plus randomized traffic against a byte-array model.
module tb_memctrl;
    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WR = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rvalid;
    logic [7:0]  if_rdata;
    logic [1:0]  mem_rw;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:1023];
    logic [7:0] mdl [0:1023];

    memctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_len(mem_len), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    // Registered byte RAM, address space folded onto 1 KiB.
    always @(posedge clk) begin
        if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
        ram_din <= ram[ram_a[9:0]];
    end

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b11) ? 4 : 2;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a[9:0]] = b;
        mdl[a[9:0]] = b;
    endtask

    // Issue one MEM command from IDLE; lat = edges from acceptance to mem_done (-1 on timeout).
    task automatic mem_op(input logic [1:0] rw, input logic [31:0] a, input logic [1:0] ln,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic [3:0][31:0] alog, output logic [3:0][7:0] dlog,
                          output logic [3:0] wlog);
        lat = -1; rd = '0; alog = '0; dlog = '0; wlog = '0;
        if_req = 1'b0; mem_rw = rw; mem_addr = a; mem_len = ln; mem_wdata = wd;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (k < 4) begin alog[k] = ram_a; dlog[k] = ram_dout; wlog[k] = ram_wr; end
            if (mem_done) begin lat = k; rd = mem_rdata; break; end
        end
        mem_rw = 2'b00; mem_addr = $urandom; mem_wdata = $urandom;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 0; if_addr = 0; mem_rw = 0; mem_addr = 0; mem_len = 0; mem_wdata = 0;
        for (int i = 0; i < 1024; i++) begin ram[i] = 8'h00; mdl[i] = 8'h00; end
        #2 rst = 1'b0;
        #10;
        checks++;
        if ({if_rvalid, if_rdata, mem_done, mem_rdata, ram_a, ram_wr, ram_dout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rv=%b rd=%h md=%b mr=%h ra=%h rw=%b do=%h exp all 0",
                     if_rvalid, if_rdata, mem_done, mem_rdata, ram_a, ram_wr, ram_dout);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({if_rvalid, mem_done, ram_wr} !== 3'b000) begin
            errors++; $display("FAIL reset_idle got %b exp 000", {if_rvalid, mem_done, ram_wr});
        end
    endtask

    task automatic test_if_burst();
        logic [7:0] exp_b [4];
        logic       exp_v;
        exp_b = '{8'h13, 8'h05, 8'h10, 8'h00};
        for (int i = 0; i < 4; i++) preload(i, exp_b[i]);
        for (int i = 0; i < 8; i++) begin
            if_req = (i < 4); if_addr = i;
            @(posedge clk); #1;
            if (i < 4) begin
                checks++;
                if (ram_a !== 32'(i) || ram_wr !== 1'b0) begin
                    errors++; $display("FAIL burst_addr i=%0d got %h/%b exp %h/0", i, ram_a, ram_wr, i);
                end
            end
            exp_v = (i >= 2 && i <= 5);
            checks++;
            if (if_rvalid !== exp_v) begin
                errors++; $display("FAIL burst_vld i=%0d got %b exp %b", i, if_rvalid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (if_rdata !== exp_b[i-2]) begin
                    errors++; $display("FAIL burst_data i=%0d got %h exp %h", i, if_rdata, exp_b[i-2]);
                end
            end
        end
        if_req = 1'b0;
    endtask

    task automatic test_mem_word_read();
        int lat; logic [31:0] rd; logic [3:0][31:0] al; logic [3:0][7:0] dl; logic [3:0] wl;
        preload(32'h100, 8'h78); preload(32'h101, 8'h56); preload(32'h102, 8'h34); preload(32'h103, 8'h12);
        mem_op(RD, 32'h100, 2'b11, 32'h0, lat, rd, al, dl, wl);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL wrd_latency got %0d exp 5", lat); end
        checks++;
        if (rd !== 32'h12345678) begin errors++; $display("FAIL wrd_data got %h exp 12345678", rd); end
        checks++;
        if (al !== {32'h103, 32'h102, 32'h101, 32'h100}) begin
            errors++; $display("FAIL wrd_addrs got %h exp 00000103000001020000010100000100", al);
        end
        checks++;
        if (wl !== 4'b0000) begin errors++; $display("FAIL wrd_ramwr got %b exp 0000", wl); end
        checks++;
        if (mem_rdata !== 32'h12345678) begin errors++; $display("FAIL wrd_hold got %h exp 12345678", mem_rdata); end
    endtask

    task automatic test_mem_half_write();
        int lat; logic [31:0] rd; logic [3:0][31:0] al; logic [3:0][7:0] dl; logic [3:0] wl;
        preload(32'h200, 8'h55); preload(32'h201, 8'h55); preload(32'h202, 8'h55);
        mem_op(WR, 32'h200, 2'b01, 32'h0000ABCD, lat, rd, al, dl, wl);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL hwr_latency got %0d exp 2", lat); end
        checks++;
        if (wl !== 4'b0011) begin errors++; $display("FAIL hwr_wr_pattern got %b exp 0011", wl); end
        checks++;
        if (al[0] !== 32'h200 || al[1] !== 32'h201 || dl[0] !== 8'hCD || dl[1] !== 8'hAB) begin
            errors++; $display("FAIL hwr_beats got %h=%h %h=%h exp 200=cd 201=ab", al[0], dl[0], al[1], dl[1]);
        end
        checks++;
        if (ram_wr !== 1'b0) begin errors++; $display("FAIL hwr_wr_after got %b exp 0", ram_wr); end
        checks++;
        if ({ram[10'h200], ram[10'h201], ram[10'h202]} !== 24'hCDAB55) begin
            errors++; $display("FAIL hwr_ram got %h%h%h exp cdab55", ram[10'h200], ram[10'h201], ram[10'h202]);
        end
    endtask

    task automatic test_collision();
        logic extra;
        preload(32'h4, 8'hA4); preload(32'h5, 8'hA5); preload(32'h8, 8'h88);
        if_req = 1'b1; if_addr = 32'h4; mem_rw = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (ram_a !== 32'h4) begin errors++; $display("FAIL col_if_addr got %h exp 4", ram_a); end
        if_addr = 32'h5; mem_rw = RD; mem_addr = 32'h8; mem_len = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (ram_a !== 32'h8 || if_rvalid !== 1'b0) begin
            errors++; $display("FAIL col_accept got a=%h rv=%b exp a=8 rv=0", ram_a, if_rvalid);
        end
        if_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 8'hA4 || mem_done !== 1'b0) begin
            errors++; $display("FAIL col_if_return got rv=%b d=%h md=%b exp 1 a4 0", if_rvalid, if_rdata, mem_done);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_done !== 1'b1 || mem_rdata !== 32'h00000088) begin
            errors++; $display("FAIL col_mem got md=%b rd=%h exp 1 00000088", mem_done, mem_rdata);
        end
        mem_rw = 2'b00;
        extra = if_rvalid;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (if_rvalid) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0) begin errors++; $display("FAIL col_dropped got response %b exp 0", extra); end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] rd; logic [3:0][31:0] al; logic [3:0][7:0] dl; logic [3:0] wl;
        preload(32'hFFFFFFFE, 8'h11); preload(32'hFFFFFFFF, 8'h22); preload(32'h0, 8'h33); preload(32'h1, 8'h44);
        mem_op(RD, 32'hFFFFFFFE, 2'b11, 32'h0, lat, rd, al, dl, wl);
        checks++;
        if (al !== {32'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE}) begin
            errors++; $display("FAIL wrap_addrs got %h %h %h %h exp fffffffe ffffffff 0 1", al[0], al[1], al[2], al[3]);
        end
        checks++;
        if (rd !== 32'h44332211 || lat !== 5) begin
            errors++; $display("FAIL wrap_data got %h lat %0d exp 44332211 lat 5", rd, lat);
        end
    endtask

    task automatic test_random();
        int lat, nb, kind, n;
        logic [31:0] rd, a, wd, ak, exp_w;
        logic [3:0][31:0] al; logic [3:0][7:0] dl; logic [3:0] wl;
        logic [31:0] qa [4];
        logic bad;
        for (int i = 0; i < 1024; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            ram[i] = b; mdl[i] = b;
        end
        for (int op = 0; op < 40; op++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                n = $urandom_range(1, 4);
                for (int i = 0; i < 4; i++) qa[i] = $urandom;
                for (int i = 0; i < n + 2; i++) begin
                    if_req = (i < n); if_addr = qa[i % 4];
                    @(posedge clk); #1;
                    checks++;
                    if (if_rvalid !== (i >= 2)) begin
                        errors++; $display("FAIL rnd_if_vld op=%0d i=%0d got %b", op, i, if_rvalid);
                    end else if (i >= 2) begin
                        checks++;
                        if (if_rdata !== mdl[qa[i-2][9:0]]) begin
                            errors++; $display("FAIL rnd_if_data a=%h got %h exp %h", qa[i-2], if_rdata, mdl[qa[i-2][9:0]]);
                        end
                    end
                end
                if_req = 1'b0;
                @(posedge clk); #1;
            end else if (kind == 1 || kind == 2) begin
                a = $urandom; wd = $urandom; mem_len = 2'($urandom);
                nb = nbytes(mem_len);
                mem_op((kind == 1) ? RD : WR, a, mem_len, wd, lat, rd, al, dl, wl);
                checks++;
                if (lat !== ((kind == 1) ? nb + 1 : nb)) begin
                    errors++; $display("FAIL rnd_latency kind=%0d len=%0d got %0d", kind, nb, lat);
                end
                if (kind == 1) begin
                    exp_w = '0;
                    for (int k = 0; k < nb; k++) begin ak = a + k; exp_w[8*k +: 8] = mdl[ak[9:0]]; end
                    checks++;
                    if (rd !== exp_w) begin errors++; $display("FAIL rnd_rdata a=%h got %h exp %h", a, rd, exp_w); end
                end else begin
                    for (int k = 0; k < nb; k++) begin ak = a + k; mdl[ak[9:0]] = wd[8*k +: 8]; end
                    checks++;
                    if (wl !== 4'((1 << nb) - 1)) begin errors++; $display("FAIL rnd_wr_beats got %b len %0d", wl, nb); end
                    for (int k = 0; k < nb; k++) begin
                        ak = a + k;
                        checks++;
                        if (ram[ak[9:0]] !== mdl[ak[9:0]]) begin
                            errors++; $display("FAIL rnd_ram a=%h got %h exp %h", ak, ram[ak[9:0]], mdl[ak[9:0]]);
                        end
                    end
                end
            end else begin
                a = $urandom; bad = 1'b0;
                mem_rw = 2'b11; mem_addr = $urandom; if_req = 1'b1; if_addr = a;
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk); #1;
                    if_req = 1'b0;
                    if (mem_done || ram_wr) bad = 1'b1;
                end
                mem_rw = 2'b00;
                checks++;
                if (bad !== 1'b0 || if_rvalid !== 1'b1 || if_rdata !== mdl[a[9:0]]) begin
                    errors++; $display("FAIL rnd_reserved got bad=%b rv=%b d=%h exp 0 1 %h", bad, if_rvalid, if_rdata, mdl[a[9:0]]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic [31:0] rd; logic [3:0][31:0] al; logic [3:0][7:0] dl; logic [3:0] wl;
        logic bad;
        for (int i = 0; i < 4; i++) preload(32'h300 + i, 8'h11);
        mem_rw = WR; mem_addr = 32'h300; mem_len = 2'b11; mem_wdata = 32'hDDCCBBAA;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        checks++;
        if (ram_wr !== 1'b1 || ram_a !== 32'h302) begin
            errors++; $display("FAIL rmw_byte2 got wr=%b a=%h exp 1 302", ram_wr, ram_a);
        end
        rst = 1'b0; mem_rw = 2'b00;
        #1;
        checks++;
        if ({if_rvalid, if_rdata, mem_done, mem_rdata, ram_a, ram_wr, ram_dout} !== '0) begin
            errors++; $display("FAIL rmw_async got wr=%b a=%h md=%b exp all 0", ram_wr, ram_a, mem_done);
        end
        bad = 1'b0;
        for (int i = 0; i < 2; i++) begin @(posedge clk); #1; if (mem_done || ram_wr) bad = 1'b1; end
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (mem_done || ram_wr) bad = 1'b1; end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL rmw_no_done got activity %b exp 0", bad); end
        checks++;
        if ({ram[10'h300], ram[10'h301], ram[10'h302], ram[10'h303]} !== 32'hAABB1111) begin
            errors++; $display("FAIL rmw_ram got %h %h %h %h exp aa bb 11 11",
                               ram[10'h300], ram[10'h301], ram[10'h302], ram[10'h303]);
        end
        mem_op(RD, 32'h300, 2'b00, 32'h0, lat, rd, al, dl, wl);
        checks++;
        if (lat !== 2 || rd !== 32'h000000AA) begin
            errors++; $display("FAIL rmw_recover got lat %0d data %h exp 2 000000aa", lat, rd);
        end
    endtask

    initial begin
        test_reset();
        test_if_burst();
        test_mem_word_read();
        test_mem_half_write();
        test_collision();
        test_wrap();
        test_random();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
